// File: rtl/operator_arbiter_if.sv
// Bundle of the two request channels, the operator drive/result lines and the
// response channel between operator_arbiter (slave) and its surroundings (master).
interface operator_arbiter_if #(
  parameter int WIDTH = 2
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req0_op;
  logic             req0_ready;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] req1_op;
  logic             req1_ready;

  logic [WIDTH-1:0] opr_a;
  logic [WIDTH-1:0] opr_b;
  logic [WIDTH-1:0] opr_sel;
  logic [WIDTH-1:0] opr_s;

  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_ready;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output opr_a, opr_b, opr_sel,
    input  opr_s,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  opr_a, opr_b, opr_sel,
    output opr_s,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/operator_arbiter.sv
// Round-robin sharing of one combinational operator between two requesters:
// accept, hold operands for SETTLE cycles, capture result, return it with its id.
module operator_arbiter #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  operator_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state_q;
  state_t     state_d;
  logic       last_grant;
  logic [3:0] settle_cnt;
  logic       grant1;
  logic       req0_rdy;
  logic       req1_rdy;
  logic       accept;
  logic       capture;
  logic       rsp_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant1   = 1'b0;
    req0_rdy = 1'b0;
    req1_rdy = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time goes next.
        if (bus.req0_valid && bus.req1_valid) grant1 = ~last_grant;
        else                                  grant1 = bus.req1_valid;
        req0_rdy = rst_n & bus.req0_valid & ~grant1;
        req1_rdy = rst_n & bus.req1_valid &  grant1;
        accept   = req0_rdy | req1_rdy;
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (settle_cnt == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready = req0_rdy;
  assign bus.req1_ready = req1_rdy;
  assign busy           = (state_q != IDLE);

  // Accept stage: operands latched and held on the operator until capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.opr_a   <= '0;
      bus.opr_b   <= '0;
      bus.opr_sel <= '0;
      bus.rsp_id  <= 1'b0;
      last_grant  <= 1'b1;
      settle_cnt  <= 4'd0;
    end else if (accept) begin
      bus.opr_a   <= grant1 ? bus.req1_a  : bus.req0_a;
      bus.opr_b   <= grant1 ? bus.req1_b  : bus.req0_b;
      bus.opr_sel <= grant1 ? bus.req1_op : bus.req0_op;
      bus.rsp_id  <= grant1;
      last_grant  <= grant1;
      settle_cnt  <= SETTLE_LOAD;
    end else if (state_q == ISSUE && settle_cnt != 4'd0) begin
      settle_cnt  <= settle_cnt - 4'd1;
    end
  end

  // Capture stage: result held on the response channel until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      done_count    <= '0;
    end else if (capture) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_data  <= bus.opr_s;
    end else if (rsp_fire) begin
      bus.rsp_valid <= 1'b0;
      done_count    <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_operator_arbiter.sv
// Directed bench for operator_arbiter: SETTLE=1 instance for the main flows and
// a SETTLE=3 instance for the stalled-response case; scoreboard of {id,data}.
module tb_operator_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy_a, busy_b;
  logic [7:0] done_a, done_b;

  int vectors = 0;
  int miscompares = 0;
  logic [2:0] sb_q[$];

  always #5 clk = ~clk;

  operator_arbiter_if #(.WIDTH(2)) ifa ();
  operator_arbiter_if #(.WIDTH(2)) ifb ();

  function automatic logic [1:0] op_model(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  assign ifa.opr_s = op_model(ifa.opr_a, ifa.opr_b, ifa.opr_sel);
  assign ifb.opr_s = op_model(ifb.opr_a, ifb.opr_b, ifb.opr_sel);

  operator_arbiter #(.WIDTH(2), .SETTLE(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a), .done_count(done_a));

  operator_arbiter #(.WIDTH(2), .SETTLE(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .busy(busy_b), .done_count(done_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic id, input logic [1:0] data);
    logic [2:0] e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(1), 32'(0));
    end else begin
      e = sb_q.pop_front();
      check({tag, "_id"}, 32'(id), 32'(e[2]));
      check({tag, "_data"}, 32'(data), 32'(e[1:0]));
    end
  endtask

  // One complete operation on the SETTLE=1 instance, rsp_ready held high.
  task automatic do_op_a(input logic id, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] op);
    int n;
    if (id) begin
      ifa.req1_a = a; ifa.req1_b = b; ifa.req1_op = op; ifa.req1_valid = 1'b1;
    end else begin
      ifa.req0_a = a; ifa.req0_b = b; ifa.req0_op = op; ifa.req0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(id ? ifa.req1_ready : ifa.req0_ready) && n < 20) begin
      tick();
      n++;
    end
    check("accept_wait", 32'(n), 32'(0));
    sb_q.push_back({id, op_model(a, b, op)});
    tick();
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    n = 0;
    while (!ifa.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("settle_latency", 32'(n), 32'(1));
    pop_check("op_rsp", ifa.rsp_id, ifa.rsp_data);
    tick();
  endtask

  initial begin
    int cyc, last_acc, accepts, responses;
    logic exp_g, drop;

    ifa.req0_valid = 1'b1; ifa.req0_a = 2'd3; ifa.req0_b = 2'd3; ifa.req0_op = 2'd3;
    ifa.req1_valid = 1'b1; ifa.req1_a = 2'd0; ifa.req1_b = 2'd0; ifa.req1_op = 2'd0;
    ifa.rsp_ready  = 1'b1;
    ifb.req0_valid = 1'b0; ifb.req0_a = 2'd0; ifb.req0_b = 2'd0; ifb.req0_op = 2'd0;
    ifb.req1_valid = 1'b0; ifb.req1_a = 2'd0; ifb.req1_b = 2'd0; ifb.req1_op = 2'd0;
    ifb.rsp_ready  = 1'b0;

    // Reset state with requests pending: readies must stay low.
    tick();
    check("rst_req0_ready", 32'(ifa.req0_ready), 32'(0));
    check("rst_req1_ready", 32'(ifa.req1_ready), 32'(0));
    check("rst_rsp_valid",  32'(ifa.rsp_valid),  32'(0));
    check("rst_opr",        32'({ifa.opr_a, ifa.opr_b, ifa.opr_sel}), 32'(0));
    check("rst_busy",       32'(busy_a), 32'(0));
    check("rst_done",       32'(done_a), 32'(0));
    ifa.req0_valid = 1'b0;
    ifa.req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Single operation: 3+2 mod 4 = 1.
    do_op_a(1'b0, 2'd3, 2'd2, 2'd0);
    check("first_done", 32'(done_a), 32'(1));
    check("first_rsp_clear", 32'(ifa.rsp_valid), 32'(0));

    // Both requesters continuously valid: grants alternate from 0.
    apply_reset();
    ifa.req0_a = 2'd1; ifa.req0_b = 2'd1; ifa.req0_op = 2'd2; ifa.req0_valid = 1'b1;
    ifa.req1_a = 2'd2; ifa.req1_b = 2'd1; ifa.req1_op = 2'd3; ifa.req1_valid = 1'b1;
    #1;
    cyc = 0; last_acc = -1; accepts = 0; responses = 0; exp_g = 1'b0; drop = 1'b0;
    while ((accepts < 4 || responses < 4) && cyc < 40) begin
      if (ifa.req0_ready || ifa.req1_ready) begin
        check("grant_order", 32'(ifa.req1_ready), 32'(exp_g));
        check("grant_onehot", 32'(ifa.req0_ready & ifa.req1_ready), 32'(0));
        if (last_acc >= 0) check("accept_spacing", 32'(cyc - last_acc), 32'(3));
        sb_q.push_back(ifa.req1_ready ? {1'b1, op_model(2'd2, 2'd1, 2'd3)}
                                      : {1'b0, op_model(2'd1, 2'd1, 2'd2)});
        last_acc = cyc;
        exp_g = ~exp_g;
        accepts++;
        if (accepts == 4) drop = 1'b1;
      end
      if (ifa.rsp_valid) begin
        pop_check("alt_rsp", ifa.rsp_id, ifa.rsp_data);
        responses++;
      end
      tick();
      cyc++;
      if (drop) begin
        ifa.req0_valid = 1'b0;
        ifa.req1_valid = 1'b0;
      end
    end
    check("alt_timeout", 32'(cyc < 40), 32'(1));
    tick();
    check("alt_done", 32'(done_a), 32'(4));

    // SETTLE=3 instance, requester 1, response stalled for 5 cycles.
    ifb.req1_a = 2'd0; ifb.req1_b = 2'd1; ifb.req1_op = 2'd1; ifb.req1_valid = 1'b1;
    #1;
    check("b_req1_ready", 32'(ifb.req1_ready), 32'(1));
    sb_q.push_back({1'b1, op_model(2'd0, 2'd1, 2'd1)});
    tick();
    ifb.req1_valid = 1'b0;
    ifb.req0_a = 2'd2; ifb.req0_b = 2'd2; ifb.req0_op = 2'd0; ifb.req0_valid = 1'b1;
    #1;
    check("b_busy", 32'(busy_b), 32'(1));
    check("b_issue_req0_ready", 32'(ifb.req0_ready), 32'(0));
    for (int k = 0; k < 2; k++) begin
      tick();
      check("b_early_valid", 32'(ifb.rsp_valid), 32'(0));
      check("b_issue_req0_ready", 32'(ifb.req0_ready), 32'(0));
    end
    tick();
    check("b_valid_rise", 32'(ifb.rsp_valid), 32'(1));
    pop_check("b_rsp", ifb.rsp_id, ifb.rsp_data);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("b_stall_valid", 32'(ifb.rsp_valid), 32'(1));
      check("b_stall_data",  32'(ifb.rsp_data), 32'(3));
      check("b_stall_id",    32'(ifb.rsp_id), 32'(1));
      check("b_stall_req0_ready", 32'(ifb.req0_ready), 32'(0));
    end
    ifb.rsp_ready = 1'b1;
    tick();
    check("b_rsp_clear", 32'(ifb.rsp_valid), 32'(0));
    check("b_done", 32'(done_b), 32'(1));
    check("b_idle_req0_ready", 32'(ifb.req0_ready), 32'(1));
    check("b_opr_hold", 32'({ifb.opr_a, ifb.opr_b, ifb.opr_sel}), 32'({2'd0, 2'd1, 2'd1}));
    ifb.req0_valid = 1'b0;

    // Reset asserted during ISSUE drops the operation immediately.
    do_op_a(1'b1, 2'd1, 2'd2, 2'd1);
    ifa.req0_a = 2'd3; ifa.req0_b = 2'd3; ifa.req0_op = 2'd3; ifa.req0_valid = 1'b1;
    #1;
    tick();
    check("mid_busy", 32'(busy_a), 32'(1));
    check("mid_opr_a", 32'(ifa.opr_a), 32'(3));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_opr", 32'({ifa.opr_a, ifa.opr_b, ifa.opr_sel}), 32'(0));
    check("mid_rst_busy", 32'(busy_a), 32'(0));
    check("mid_rst_done", 32'(done_a), 32'(0));
    check("mid_rst_ready", 32'(ifa.req0_ready), 32'(0));
    check("mid_rst_valid", 32'(ifa.rsp_valid), 32'(0));
    ifa.req0_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_no_rsp", 32'(ifa.rsp_valid), 32'(0));
    end

    // 256 completions wrap the 8-bit counter.
    for (int i = 0; i < 255; i++) begin
      do_op_a(1'(i), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)));
    end
    check("wrap_255", 32'(done_a), 32'(255));
    do_op_a(1'b0, 2'd2, 2'd3, 2'd2);
    check("wrap_0", 32'(done_a), 32'(0));
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operator_arbiter.md
Name: operator_arbiter

Overview:
- Two-requester controller that shares one combinational 2-bit `operator` instance (inputs a, b, op select; output s) between independent clients.
- Arbitrates round-robin, registers the winning operands onto the operator and holds them for a programmable settle time.
- Captures the result and returns it over a valid/ready response channel tagged with the requester id.
- Sits directly in front of the `operator` in the lab datapath.

Parameters:
- WIDTH, 2, bit width of operands, op select and result; must match the `operator` instance.
- SETTLE, 1, cycles the operator inputs are held before the result is sampled; legal range 1..15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_a, req0_b, req0_op  input  WIDTH each  requester 0 operands and op select
- req0_ready  output  1  requester 0 operation accepted this cycle
- req1_valid, req1_a, req1_b, req1_op, req1_ready  same as requester 0, for requester 1
- opr_a, opr_b, opr_sel  output  WIDTH each  registered drive to operator inputs a, b, op select
- opr_s  input  WIDTH  operator result
- rsp_valid  output  1  result available
- rsp_id  output  1  requester that owns the result
- rsp_data  output  WIDTH  captured result
- rsp_ready  input  1  consumer takes the result
- busy  output  1  high in ISSUE or RESP
- done_count  output  CNT_W  completed-response counter

Behaviour:
- Reset (rst_n low, async): state=IDLE; opr_a/opr_b/opr_sel=0; rsp_valid=0; rsp_id=0; rsp_data=0; busy=0; done_count=0; last_grant=1 (requester 0 wins first tie). req0_ready/req1_ready forced 0 while rst_n low.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = the single valid requester, or on tie the requester != last_grant.
  - reqN_ready is combinational, high only for the granted requester while in IDLE; the accept is (valid & ready).
  - On the accept edge: latch a/b/op into opr_a/opr_b/opr_sel, set rsp_id=N and last_grant=N, load settle counter = SETTLE-1, go to ISSUE.
- ISSUE:
  - opr_* held constant.
  - If counter==0: capture rsp_data<=opr_s, set rsp_valid=1, go to RESP; else decrement.
  - rsp_valid therefore rises exactly SETTLE cycles after the accept edge.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready.
  - On the (rsp_valid & rsp_ready) edge: clear rsp_valid, done_count++ (wraps to 0 after 2^CNT_W-1), go to IDLE.
  - No new accept occurs in that same cycle; minimum spacing between accepts is SETTLE+2 cycles.
- reqN_ready is 0 outside IDLE.
- Requesters must hold valid and operands stable until ready; a requester deasserting valid before grant is simply not served.
- opr_* keep their last values while IDLE (no toggling on unaccepted requests).
- Reset mid-operation (ISSUE or RESP): the operation is dropped with no response, done_count cleared, and the requester must re-request.
- Result arithmetic is entirely the operator's; the controller performs no modification of operands or result.

Test Plan:
- Bench stub operator: op0 = a+b mod 4, op1 = a-b mod 4, op2 = a&b, op3 = a|b.
- Reset then req0 {a=3,b=2,op=0}, SETTLE=1, rsp_ready=1 -> req0_ready high in first valid cycle; one cycle later rsp_valid=1, rsp_id=0, rsp_data=1; done_count=1 after handshake.
- Both requesters valid continuously, req0 {1,1,op2}, req1 {2,1,op3} -> grants alternate 0,1,0,1; responses 1,3,1,3 with matching rsp_id; each accept is SETTLE+2 cycles after the previous one.
- SETTLE=3, req1 {0,1,op1}, rsp_ready held low 5 cycles -> rsp_valid rises 3 cycles after accept with rsp_data=3; data and id stable for all 5 stall cycles; req0_ready stays 0 throughout.
- Assert rst_n low during ISSUE -> outputs immediately at reset values with no clock edge needed, no response is produced, and the next request is served normally.
- Perform 256 ops with CNT_W=8 -> done_count wraps to 0.
